// File: rtl/eeprom_slave_model.sv
// ---------------------------------------------------------------------------
// eeprom_slave_model
//   Two-wire serial EEPROM slave (24Cxx-style, 11-bit address) for use as a
//   bus partner of an EEPROM write/read controller. SCL/SDA are oversampled
//   by CLK: all protocol decisions use synchronized copies and their edges.
//
//   Ports
//     CLK        oversampling clock (>= 8x SCL)
//     RESET      synchronous, active-high
//     SCL        serial clock from the master
//     SDA        serial data; this block only pulls low or releases
//     cur_addr   internal address pointer
//     wr_strobe  one-CLK pulse when a written byte lands in memory
//     rd_strobe  one-CLK pulse when a read byte has been fully shifted out
//     busy       high from START until STOP / abort back to IDLE
// ---------------------------------------------------------------------------
module eeprom_slave_model #(
   parameter int          MEM_DEPTH = 2048,
   parameter logic [3:0]  DEV_CODE  = 4'b1010
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        SCL,
   inout  wire         SDA,
   output logic [10:0] cur_addr,
   output logic        wr_strobe,
   output logic        rd_strobe,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;

   state_t      state;
   logic [7:0]  mem [0:MEM_DEPTH-1];

   logic        scl_s1, scl_s2, scl_d;
   logic        sda_s1, sda_s2, sda_d;
   logic        sda_oe;       // 1 = pull SDA low
   logic [3:0]  bit_cnt;      // rising edges seen in the current byte
   logic [6:0]  sr;           // first seven bits of the byte being received
   logic [7:0]  rd_byte;
   logic        ack_ph;       // 0: waiting to assert ACK, 1: ACK on the bus
   logic        rw;
   logic        mst_nack;

   logic        scl_rise, scl_fall, start_c, stop_c, mem_we;
   logic [7:0]  byte_in;
   logic [10:0] addr_inc;

   assign SDA = sda_oe ? 1'b0 : 1'bz;

   assign scl_rise = scl_s2 & ~scl_d;
   assign scl_fall = ~scl_s2 & scl_d;
   // START/STOP are SDA transitions while SCL is stably high
   assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
   assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;
   // full byte as of the current rising edge (MSB first)
   assign byte_in  = {sr, sda_s2};
   assign addr_inc = (cur_addr == 11'(MEM_DEPTH - 1)) ? 11'd0 : cur_addr + 11'd1;

   // Commit on the 8th rising edge of a data byte; START/STOP/RESET on the
   // same CLK win, so a byte cut short never reaches memory.
   assign mem_we = !RESET && !start_c && !stop_c && (state == WDATA) &&
                   scl_rise && (bit_cnt == 4'd7);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         scl_s1 <= 1'b1;  scl_s2 <= 1'b1;  scl_d <= 1'b1;
         sda_s1 <= 1'b1;  sda_s2 <= 1'b1;  sda_d <= 1'b1;
      end else begin
         scl_s1 <= SCL;    scl_s2 <= scl_s1;  scl_d <= scl_s2;
         sda_s1 <= SDA;    sda_s2 <= sda_s1;  sda_d <= sda_s2;
      end
   end

   // Memory has no reset: contents survive RESET.
   always_ff @(posedge CLK) begin
      if (mem_we) mem[cur_addr] <= byte_in;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         sda_oe    <= 1'b0;
         cur_addr  <= '0;
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         busy      <= 1'b0;
         bit_cnt   <= '0;
         sr        <= '0;
         rd_byte   <= '0;
         ack_ph    <= 1'b0;
         rw        <= 1'b0;
         mst_nack  <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         if (start_c) begin
            state   <= CTRL;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b1;
         end else if (stop_c) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               CTRL, ADDR, WDATA: begin
                  if (scl_rise) begin
                     sr      <= byte_in[6:0];
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        ack_ph  <= 1'b0;
                        case (state)
                           CTRL: begin
                              if (byte_in[7:4] != DEV_CODE) begin
                                 state <= IDLE;
                                 busy  <= 1'b0;
                              end else begin
                                 // block bits land now so RDATA entry sees the full address
                                 state          <= CTRL_ACK;
                                 cur_addr[10:8] <= byte_in[3:1];
                                 rw             <= byte_in[0];
                              end
                           end
                           ADDR: begin
                              state         <= ADDR_ACK;
                              cur_addr[7:0] <= byte_in;
                           end
                           default: begin
                              state     <= WDATA_ACK;
                              wr_strobe <= 1'b1;
                           end
                        endcase
                     end
                  end
               end

               // First SCL fall after the byte: pull ACK. Second fall (end of
               // the 9th pulse): release and move on.
               CTRL_ACK, ADDR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     if (!ack_ph) begin
                        sda_oe <= 1'b1;
                        ack_ph <= 1'b1;
                     end else begin
                        sda_oe  <= 1'b0;
                        ack_ph  <= 1'b0;
                        bit_cnt <= '0;
                        case (state)
                           CTRL_ACK: begin
                              if (rw) begin
                                 state   <= RDATA;
                                 rd_byte <= mem[cur_addr];
                                 sda_oe  <= ~mem[cur_addr][7];
                              end else begin
                                 state <= ADDR;
                              end
                           end
                           ADDR_ACK: state <= WDATA;
                           default: begin
                              state    <= WDATA;
                              cur_addr <= addr_inc;
                           end
                        endcase
                     end
                  end
               end

               // MSB is already on the bus at entry; each fall presents the
               // next bit until all eight have been clocked out.
               RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe    <= 1'b0;
                        rd_strobe <= 1'b1;
                        cur_addr  <= addr_inc;
                        bit_cnt   <= '0;
                        state     <= RDATA_ACK;
                     end else begin
                        sda_oe <= ~rd_byte[~bit_cnt[2:0]];
                     end
                  end
               end

               RDATA_ACK: begin
                  if (scl_rise) begin
                     mst_nack <= sda_s2;
                  end else if (scl_fall) begin
                     if (mst_nack) begin
                        // master is done; sit released until STOP clears busy
                        state <= IDLE;
                     end else begin
                        state   <= RDATA;
                        bit_cnt <= '0;
                        rd_byte <= mem[cur_addr];
                        sda_oe  <= ~mem[cur_addr][7];
                     end
                  end
               end

               default: ;
            endcase
         end
      end
   end

endmodule
